// File: rtl/burst_write_if.sv
// Buffer pull port and external memory burst port of the burst write controller.
// The master modport is the controller; the slave modport is the buffer plus memory side.
interface burst_write_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int BURST_LENGTH = 16,
  parameter int SIZE_W       = 10
);
  localparam int LEN_W = $clog2(BURST_LENGTH) + 1;

  logic [SIZE_W-1:0]     buf_size_i;
  logic                  buf_valid_i;
  logic [31:0]           buf_data_i;
  logic                  buf_pull_o;
  logic                  ext_request_o;
  logic [ADDR_WIDTH-1:0] ext_address_o;
  logic [LEN_W-1:0]      ext_length_o;
  logic                  ext_grant_i;
  logic                  ext_valid_o;
  logic [31:0]           ext_data_o;
  logic                  ext_last_o;
  logic                  ext_ready_i;
  logic                  ext_done_i;
  logic                  ext_error_i;

  modport master (
    input  buf_size_i, buf_valid_i, buf_data_i, ext_grant_i, ext_ready_i, ext_done_i, ext_error_i,
    output buf_pull_o, ext_request_o, ext_address_o, ext_length_o, ext_valid_o, ext_data_o, ext_last_o
  );

  modport slave (
    output buf_size_i, buf_valid_i, buf_data_i, ext_grant_i, ext_ready_i, ext_done_i, ext_error_i,
    input  buf_pull_o, ext_request_o, ext_address_o, ext_length_o, ext_valid_o, ext_data_o, ext_last_o
  );
endinterface

// File: rtl/burst_write_controller.sv
// Drains validated words from the burst buffer into fixed-length external write bursts.
//   state     | meaning
//   IDLE      | waiting for a full burst, or a drain with a non-empty buffer
//   REQUEST   | burst request with address/length held until grant
//   TRANSFER  | pulling words through the 2-entry skid queue to the memory
//   WAIT_DONE | last word accepted, waiting for the completion
module burst_write_controller #(
  parameter int BUFFER_DEPTH = 1024,
  parameter int BURST_LENGTH = 16,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  base_load_i,
  input  logic                  drain_i,
  output logic                  busy_o,
  output logic                  error_o,
  burst_write_if.master         bus
);
  localparam int LEN_W = $clog2(BURST_LENGTH) + 1;

  typedef enum logic [1:0] {IDLE, REQUEST, TRANSFER, WAIT_DONE} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d, pulls_left_q, pushes_left_q;
  logic [ADDR_WIDTH-1:0]   addr_q, pend_addr_q;
  logic                    pend_q, inflight_q, error_q;
  logic [1:0]              count_q;
  logic [31:0]             hd_data_q, tl_data_q;
  logic                    hd_last_q, tl_last_q;
  logic [$clog2(BUFFER_DEPTH)-1:0] size_l;
  logic [31:0]             size_w;
  logic                    start, pop, push, pull, push_last, done_ok;
  logic [2:0]              occ_after_pop;

  assign size_l  = bus.buf_size_i;
  assign size_w  = 32'(size_l);
  assign len_d   = (size_w < 32'(BURST_LENGTH)) ? LEN_W'(size_w) : LEN_W'(BURST_LENGTH);
  assign pop     = bus.ext_valid_o && bus.ext_ready_i;
  assign push    = inflight_q;
  assign push_last = (pushes_left_q == LEN_W'(1));
  assign done_ok = (state_q == WAIT_DONE) && bus.ext_done_i;

  // Words already queued or still in the buffer's read pipe count against the 2 slots.
  assign occ_after_pop = ({1'b0, count_q} + {2'b00, inflight_q}) - {2'b00, pop};
  assign pull = (state_q == TRANSFER) && (pulls_left_q != '0) && (occ_after_pop < 3'd2);

  assign bus.buf_pull_o    = pull;
  assign bus.ext_request_o = (state_q == REQUEST);
  assign bus.ext_address_o = (state_q == REQUEST) ? addr_q : '0;
  assign bus.ext_length_o  = (state_q == REQUEST) ? len_q : '0;
  assign bus.ext_valid_o   = (count_q != 2'd0);
  assign bus.ext_data_o    = bus.ext_valid_o ? hd_data_q : '0;
  assign bus.ext_last_o    = bus.ext_valid_o && hd_last_q;
  assign busy_o            = (state_q != IDLE);
  assign error_o           = error_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.buf_valid_i &&
            (size_w >= 32'(BURST_LENGTH) || (drain_i && size_w != 32'd0))) begin
          start   = 1'b1;
          state_d = REQUEST;
        end
      end
      REQUEST:   if (bus.ext_grant_i) state_d = TRANSFER;
      TRANSFER:  if (pop && bus.ext_last_o) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.ext_done_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      len_q         <= '0;
      pulls_left_q  <= '0;
      pushes_left_q <= '0;
      addr_q        <= '0;
      pend_addr_q   <= '0;
      pend_q        <= 1'b0;
      inflight_q    <= 1'b0;
      error_q       <= 1'b0;
      count_q       <= 2'd0;
      hd_data_q     <= '0;
      tl_data_q     <= '0;
      hd_last_q     <= 1'b0;
      tl_last_q     <= 1'b0;
    end else begin
      inflight_q <= pull;
      error_q    <= done_ok && bus.ext_error_i;

      if (start) begin
        len_q         <= len_d;
        pulls_left_q  <= len_d;
        pushes_left_q <= len_d;
      end else begin
        if (pull) pulls_left_q  <= pulls_left_q - LEN_W'(1);
        if (push) pushes_left_q <= pushes_left_q - LEN_W'(1);
      end

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            hd_data_q <= bus.buf_data_i;
            hd_last_q <= push_last;
          end else begin
            tl_data_q <= bus.buf_data_i;
            tl_last_q <= push_last;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          hd_data_q <= tl_data_q;
          hd_last_q <= tl_last_q;
          count_q   <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            hd_data_q <= bus.buf_data_i;
            hd_last_q <= push_last;
          end else begin
            hd_data_q <= tl_data_q;
            hd_last_q <= tl_last_q;
            tl_data_q <= bus.buf_data_i;
            tl_last_q <= push_last;
          end
        end
        default: ;
      endcase

      // A load seen during a burst wins over the end-of-burst advance.
      if (state_q == IDLE) begin
        if (base_load_i) addr_q <= base_addr_i;
      end else if (done_ok) begin
        if (base_load_i)  addr_q <= base_addr_i;
        else if (pend_q)  addr_q <= pend_addr_q;
        else              addr_q <= addr_q + ADDR_WIDTH'({len_q, 2'b00});
        pend_q <= 1'b0;
      end else if (base_load_i) begin
        pend_q      <= 1'b1;
        pend_addr_q <= base_addr_i;
      end
    end
  end
endmodule

// File: tb/tb_burst_write_controller.sv
// Randomized bench for burst_write_controller: a queue-based buffer model feeds the DUT and a
// scoreboard checks burst address/length, word order, last flag, pull count and completion.
`timescale 1ns/1ps
module tb_burst_write_controller;
  localparam int AW    = 32;
  localparam int BL    = 16;
  localparam int DEPTH = 1024;
  localparam int SW    = $clog2(DEPTH);
  localparam int LW    = $clog2(BL) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic          base_load = 1'b0;
  logic          drain = 1'b0;
  logic          busy, err_o;

  int errors = 0;
  int checks = 0;
  int pulls  = 0;
  logic [31:0]   buf_q[$];
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr = '0;

  burst_write_if #(.ADDR_WIDTH(AW), .BURST_LENGTH(BL), .SIZE_W(SW)) bus();

  burst_write_controller #(.BUFFER_DEPTH(DEPTH), .BURST_LENGTH(BL), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .base_addr_i(base_addr), .base_load_i(base_load),
    .drain_i(drain), .busy_o(busy), .error_o(err_o), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  // Buffer model: registered read port, one cycle of latency after a pull.
  always @(posedge clk) begin
    if (bus.buf_pull_o) begin
      pulls++;
      bus.buf_data_i <= (buf_q.size() != 0) ? buf_q.pop_front() : 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) bus.buf_size_i = SW'(buf_q.size());

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic fill(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      buf_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic load_base(input logic [AW-1:0] a);
    base_addr = a;
    base_load = 1'b1;
    @(negedge clk);
    base_load = 1'b0;
    exp_addr  = a;
  endtask

  // rmode: 0 ready always high, 1 toggling, 2 random
  task automatic do_burst(input string name, input int exp_len, input int gdly, input int rmode,
                          input bit err, input bit do_load, input logic [AW-1:0] load_val);
    int n, beats, cyc, p0;
    bit fin, rdy, held;
    logic [31:0] hd, exp_w;
    logic hl;
    p0 = pulls;
    n = 0;
    while (!bus.ext_request_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.ext_request_o !== 1'b1) begin
      errors++;
      $display("FAIL %s request: got %b after %0d cycles, required 1", name, bus.ext_request_o, n);
      return;
    end
    checks++;
    if (bus.ext_address_o !== exp_addr) begin
      errors++;
      $display("FAIL %s address: got %h required %h", name, bus.ext_address_o, exp_addr);
    end
    checks++;
    if (bus.ext_length_o !== LW'(exp_len)) begin
      errors++;
      $display("FAIL %s length: got %0d required %0d", name, bus.ext_length_o, exp_len);
    end
    for (int g = 0; g < gdly; g++) begin
      @(negedge clk);
      checks++;
      if (bus.ext_request_o !== 1'b1 || bus.ext_address_o !== exp_addr ||
          bus.ext_length_o !== LW'(exp_len) || bus.buf_pull_o !== 1'b0) begin
        errors++;
        $display("FAIL %s request_hold: req=%b addr=%h len=%0d pull=%b, required 1/%h/%0d/0",
                 name, bus.ext_request_o, bus.ext_address_o, bus.ext_length_o, bus.buf_pull_o,
                 exp_addr, exp_len);
      end
    end
    bus.ext_grant_i = 1'b1;
    @(negedge clk);
    bus.ext_grant_i = 1'b0;

    beats = 0; cyc = 0; fin = 1'b0; held = 1'b0;
    while (!fin && cyc < 300) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.ext_ready_i = rdy;
      if (do_load && cyc == 3) begin
        base_addr = load_val;
        base_load = 1'b1;
      end else begin
        base_load = 1'b0;
      end
      if (held) begin
        checks++;
        if (bus.ext_valid_o !== 1'b1 || bus.ext_data_o !== hd || bus.ext_last_o !== hl) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b data=%h last=%b, required 1/%h/%b",
                   name, bus.ext_valid_o, bus.ext_data_o, bus.ext_last_o, hd, hl);
        end
      end
      held = 1'b0;
      if (bus.ext_valid_o === 1'b1) begin
        if (rdy) begin
          exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          checks++;
          if (bus.ext_data_o !== exp_w) begin
            errors++;
            $display("FAIL %s data beat %0d: got %h required %h", name, beats, bus.ext_data_o, exp_w);
          end
          checks++;
          if (bus.ext_last_o !== (beats == exp_len - 1)) begin
            errors++;
            $display("FAIL %s last beat %0d: got %b required %b", name, beats, bus.ext_last_o,
                     (beats == exp_len - 1));
          end
          beats++;
          if (bus.ext_last_o === 1'b1) fin = 1'b1;
        end else begin
          held = 1'b1;
          hd   = bus.ext_data_o;
          hl   = bus.ext_last_o;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.ext_ready_i = 1'b0;
    base_load = 1'b0;
    checks++;
    if (beats != exp_len) begin
      errors++;
      $display("FAIL %s beat_count: got %0d required %0d", name, beats, exp_len);
    end
    checks++;
    if (pulls - p0 != exp_len) begin
      errors++;
      $display("FAIL %s pull_count: got %0d required %0d", name, pulls - p0, exp_len);
    end
    repeat (2) begin
      checks++;
      if (busy !== 1'b1 || bus.ext_valid_o !== 1'b0 || bus.buf_pull_o !== 1'b0) begin
        errors++;
        $display("FAIL %s wait_done: busy=%b valid=%b pull=%b, required 1/0/0",
                 name, busy, bus.ext_valid_o, bus.buf_pull_o);
      end
      @(negedge clk);
    end
    bus.ext_done_i  = 1'b1;
    bus.ext_error_i = err;
    @(negedge clk);
    bus.ext_done_i  = 1'b0;
    bus.ext_error_i = 1'b0;
    checks++;
    if (busy !== 1'b0 || err_o !== err) begin
      errors++;
      $display("FAIL %s completion: busy=%b error=%b, required 0/%b", name, busy, err_o, err);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL %s error_pulse_width: got %b required 0", name, err_o);
    end
    exp_addr = do_load ? load_val : exp_addr + AW'(4 * exp_len);
  endtask

  task automatic test_reset();
    bus.buf_valid_i = 1'b0;
    bus.ext_grant_i = 1'b0;
    bus.ext_ready_i = 1'b0;
    bus.ext_done_i  = 1'b0;
    bus.ext_error_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ext_request_o, bus.ext_valid_o, bus.ext_last_o, bus.buf_pull_o, busy, err_o} !== 6'b0 ||
        bus.ext_data_o !== 32'h0 || bus.ext_address_o !== '0 || bus.ext_length_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b valid=%b last=%b pull=%b busy=%b err=%b data=%h addr=%h len=%0d, required all 0",
               bus.ext_request_o, bus.ext_valid_o, bus.ext_last_o, bus.buf_pull_o, busy, err_o,
               bus.ext_data_o, bus.ext_address_o, bus.ext_length_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_addr = '0;
    @(negedge clk);
  endtask

  task automatic test_full_burst();
    bus.buf_valid_i = 1'b1;
    load_base(32'h0000_1000);
    fill(16);
    do_burst("full_burst", 16, 0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_drain();
    int seen;
    fill(5);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ext_request_o !== 1'b0 || busy !== 1'b0 || bus.buf_pull_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL below_burst_idle: %0d active cycles, required 0", seen);
    end
    drain = 1'b1;
    do_burst("drain_5", 5, 1, 0, 1'b0, 1'b0, '0);
    drain = 1'b0;
  endtask

  task automatic test_ready_toggle();
    fill(16);
    do_burst("ready_toggle", 16, 2, 1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_base_load_mid();
    fill(16);
    do_burst("load_mid", 16, 0, 0, 1'b0, 1'b1, 32'h0000_8000);
    fill(16);
    do_burst("after_load", 16, 1, 2, 1'b0, 1'b0, '0);
  endtask

  task automatic test_error();
    fill(16);
    do_burst("error_done", 16, 0, 2, 1'b1, 1'b0, '0);
    fill(16);
    do_burst("after_error", 16, 0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random_drain();
    int n;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 15);
      fill(n);
      drain = 1'b1;
      do_burst("random_drain", n, $urandom_range(0, 3), 2, 1'($urandom_range(0, 1)), 1'b0, '0);
      drain = 1'b0;
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    int n;
    fill(16);
    n = 0;
    while (!bus.ext_request_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.ext_grant_i = 1'b1;
    @(negedge clk);
    bus.ext_grant_i = 1'b0;
    bus.ext_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.ext_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_transfer: busy=%b valid=%b, required 1/1", busy, bus.ext_valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ext_request_o, bus.ext_valid_o, bus.ext_last_o, bus.buf_pull_o, busy, err_o} !== 6'b0 ||
        bus.ext_data_o !== 32'h0 || bus.ext_address_o !== '0 || bus.ext_length_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: req=%b valid=%b last=%b pull=%b busy=%b err=%b data=%h, required all 0",
               bus.ext_request_o, bus.ext_valid_o, bus.ext_last_o, bus.buf_pull_o, busy, err_o,
               bus.ext_data_o);
    end
    bus.ext_ready_i = 1'b0;
    @(negedge clk);
    buf_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_addr = '0;
    @(negedge clk);
    load_base(32'hFFFF_FFC0);
    fill(16);
    do_burst("wrap_burst", 16, 0, 0, 1'b0, 1'b0, '0);
    fill(3);
    drain = 1'b1;
    do_burst("after_wrap", 3, 0, 0, 1'b0, 1'b0, '0);
    drain = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_drain();
    test_ready_toggle();
    test_base_load_mid();
    test_error();
    test_random_drain();
    test_reset_mid_and_wrap();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
